sap_microsequencer: RTL and testbench

// Parametrised successor to the SAP-1 controller/sequencer: a T-state sequencer plus opcode decoder that drives the datapath control word.

---
 rtl/sap_ctrl_pkg.sv | 51 +++++
 rtl/sap_microsequencer_if.sv | 40 ++++
 rtl/sap_ring_counter.sv | 45 ++++
 rtl/sap_microsequencer.sv | 138 +++++++++++++
 tb/tb_sap_microsequencer.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sap_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sap_ctrl_pkg
// Description : Opcodes, control-word layout and idle control word shared by
//               the SAP micro-sequencer, its interface and its ring counter.
// Revision    : 1.0 - initial release
// ============================================================================
package sap_ctrl_pkg;

    // Control word {Lp,Cp,Ep,Lm_bar,CE_bar,Li_bar,Ei_bar,La_bar,Ea,Su,Eu,Lb_bar,Lo_bar}
    localparam int CW_W = 13;

    localparam logic [3:0] B_LP  = 4'd12;
    localparam logic [3:0] B_CP  = 4'd11;
    localparam logic [3:0] B_EP  = 4'd10;
    localparam logic [3:0] B_LM  = 4'd9;   // active low
    localparam logic [3:0] B_CE  = 4'd8;   // active low
    localparam logic [3:0] B_LI  = 4'd7;   // active low
    localparam logic [3:0] B_EI  = 4'd6;   // active low
    localparam logic [3:0] B_LA  = 4'd5;   // active low
    localparam logic [3:0] B_EA  = 4'd4;
    localparam logic [3:0] B_SU  = 4'd3;
    localparam logic [3:0] B_EU  = 4'd2;
    localparam logic [3:0] B_LB  = 4'd1;   // active low
    localparam logic [3:0] B_LO  = 4'd0;   // active low

    // Every active-low bit high, every active-high bit low.
    localparam logic [CW_W-1:0] CW_IDLE = 13'h03E3;

    // Base opcode values; wider opcode buses zero-extend these.
    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_JMP = 4'b0011;
    localparam logic [3:0] OP_JZ  = 4'b0100;
    localparam logic [3:0] OP_JN  = 4'b0101;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // Assert one control signal: the bit takes the opposite of its idle level,
    // so callers never need to know which signals are active low.
    function automatic logic [CW_W-1:0] cw_on(input logic [CW_W-1:0] cw,
                                              input logic [3:0]      idx);
        logic [CW_W-1:0] r;
        r      = cw;
        r[idx] = ~CW_IDLE[idx];
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sap_microsequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : sap_microsequencer_if
// Description : Bus between the IR/flag/mode sources and the SAP sequencer,
//               carrying the control word and status back to the datapath.
// Revision    : 1.0 - initial release
// ============================================================================
interface sap_microsequencer_if
    import sap_ctrl_pkg::*;
#(
    parameter int NUM_T = 6,
    parameter int OP_W  = 4,
    parameter int CNT_W = 8
) ();

    logic              run_mode;
    logic              step_req;
    logic [OP_W-1:0]   opcode;
    logic              flag_z;
    logic              flag_n;
    logic [CW_W-1:0]   cw;
    logic [NUM_T-1:0]  t_state;
    logic              adv;
    logic              halted;
    logic [CNT_W-1:0]  instr_count;

    // Sequencer side
    modport slave (
        input  run_mode, step_req, opcode, flag_z, flag_n,
        output cw, t_state, adv, halted, instr_count
    );

    // Datapath / controlling side
    modport master (
        output run_mode, step_req, opcode, flag_z, flag_n,
        input  cw, t_state, adv, halted, instr_count
    );

endinterface
`default_nettype wire

// File: rtl/sap_ring_counter.sv
`default_nettype none
// ============================================================================
// Module      : sap_ring_counter
// Description : One-hot T-state ring with async clear, advance enable and a
//               synchronous wrap-to-T1 request for early instruction end.
// Revision    : 1.0 - initial release
// ============================================================================
module sap_ring_counter #(
    parameter int STATES = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              wrap_i,
    output logic [STATES-1:0] state_o
);

    logic [STATES-1:0] state_q;
    logic [STATES-1:0] state_d;

    // Rotate one place per enabled cycle, or jump back to T1 on wrap.
    always_comb begin
        state_d = state_q;
        if (en_i) begin
            if (wrap_i) begin
                state_d = STATES'(1);
            end else begin
                state_d = {state_q[STATES-2:0], state_q[STATES-1]};
            end
        end
    end

    // T-state register; clear forces T1.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= STATES'(1);
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule
`default_nettype wire

// File: rtl/sap_microsequencer.sv
`default_nettype none
// ============================================================================
// Module      : sap_microsequencer
// Description : SAP controller/sequencer: T-state ring, opcode decoder that
//               builds the datapath control word, halt flag and retired
//               instruction counter, with run / single-step advance.
// Revision    : 1.0 - initial release
// ============================================================================
module sap_microsequencer
    import sap_ctrl_pkg::*;
#(
    parameter int NUM_T     = 6,
    parameter int OP_W      = 4,
    parameter int EARLY_END = 1,
    parameter int CNT_W     = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,   // CLR: asynchronous, active high
    sap_microsequencer_if.slave bus
);

    logic              halted_q, halted_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_T-1:0]  w_t;
    logic [5:0]        w_t6;        // T1..T6 view, zero padded for small NUM_T
    logic              w_adv;
    logic              w_lda, w_add, w_sub, w_jmp, w_jz, w_jn, w_out, w_hlt, w_nop;
    logic              w_last;
    logic              w_wrap;
    logic              w_hlt_now;
    logic [CW_W-1:0]   w_cw_dec;

    // Clear participates combinationally so cw/adv drop immediately on CLR.
    assign w_adv = ~halted_q & ~rst_i & (bus.run_mode | bus.step_req);

    if (NUM_T >= 6) begin : g_t6_direct
        assign w_t6 = w_t[5:0];
    end else begin : g_t6_pad
        assign w_t6 = {{(6-NUM_T){1'b0}}, w_t};
    end

    assign w_lda = (bus.opcode == OP_W'(OP_LDA));
    assign w_add = (bus.opcode == OP_W'(OP_ADD));
    assign w_sub = (bus.opcode == OP_W'(OP_SUB));
    assign w_jmp = (bus.opcode == OP_W'(OP_JMP));
    assign w_jz  = (bus.opcode == OP_W'(OP_JZ));
    assign w_jn  = (bus.opcode == OP_W'(OP_JN));
    assign w_out = (bus.opcode == OP_W'(OP_OUT));
    assign w_hlt = (bus.opcode == OP_W'(OP_HLT));
    assign w_nop = ~(w_lda | w_add | w_sub | w_jmp | w_jz | w_jn | w_out | w_hlt);

    // Last state that does useful work; jumps finish in T4 taken or not.
    assign w_last = (w_nop & w_t6[2])
                  | ((w_out | w_jmp | w_jz | w_jn) & w_t6[3])
                  | (w_lda & w_t6[4])
                  | ((w_add | w_sub) & w_t6[5]);

    assign w_wrap    = (EARLY_END != 0) ? w_last : w_t[NUM_T-1];
    assign w_hlt_now = w_hlt & w_t6[3];

    // The ring stays put on the HLT advance so t_state freezes at T4.
    sap_ring_counter #(
        .STATES (NUM_T)
    ) u_ring (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (w_adv & ~w_hlt_now),
        .wrap_i  (w_wrap),
        .state_o (w_t)
    );

    // Microcode: fetch is common, execute depends on opcode and flags.
    always_comb begin
        w_cw_dec = CW_IDLE;
        if (w_t6[0]) begin
            w_cw_dec = cw_on(cw_on(w_cw_dec, B_EP), B_LM);
        end
        if (w_t6[1]) begin
            w_cw_dec = cw_on(w_cw_dec, B_CP);
        end
        if (w_t6[2]) begin
            w_cw_dec = cw_on(cw_on(w_cw_dec, B_CE), B_LI);
        end
        if (w_t6[3]) begin
            if (w_lda | w_add | w_sub) begin
                w_cw_dec = cw_on(cw_on(w_cw_dec, B_EI), B_LM);
            end
            if (w_out) begin
                w_cw_dec = cw_on(cw_on(w_cw_dec, B_EA), B_LO);
            end
            if (w_jmp | (w_jz & bus.flag_z) | (w_jn & bus.flag_n)) begin
                w_cw_dec = cw_on(cw_on(w_cw_dec, B_EI), B_LP);
            end
        end
        if (w_t6[4]) begin
            if (w_lda) begin
                w_cw_dec = cw_on(cw_on(w_cw_dec, B_CE), B_LA);
            end
            if (w_add | w_sub) begin
                w_cw_dec = cw_on(cw_on(w_cw_dec, B_CE), B_LB);
            end
        end
        if (w_t6[5] & (w_add | w_sub)) begin
            w_cw_dec = cw_on(cw_on(w_cw_dec, B_EU), B_LA);
            if (w_sub) begin
                w_cw_dec = cw_on(w_cw_dec, B_SU);
            end
        end
    end

    // Halt latches on the HLT advance; an instruction retires on wrap or halt.
    always_comb begin
        halted_d = halted_q | (w_adv & w_hlt_now);
        cnt_d    = cnt_q;
        if (w_adv & (w_wrap | w_hlt_now)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Halt flag and retired-instruction counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.cw          = w_adv ? w_cw_dec : CW_IDLE;
    assign bus.t_state     = w_t;
    assign bus.adv         = w_adv;
    assign bus.halted      = halted_q;
    assign bus.instr_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sap_microsequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sap_microsequencer
// Description : Self-checking bench for sap_microsequencer: four instances
//               (NUM_T 6/8, EARLY_END 1/0) driven by one shared stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sap_microsequencer;

    // Hand-derived control words; bit order
    // {Lp,Cp,Ep,Lm_,CE_,Li_,Ei_,La_,Ea,Su,Eu,Lb_,Lo_}
    localparam logic [12:0] C_IDLE = 13'h03E3; // all _bar high
    localparam logic [12:0] C_T1   = 13'h05E3; // Ep, Lm
    localparam logic [12:0] C_T2   = 13'h0BE3; // Cp
    localparam logic [12:0] C_T3   = 13'h0263; // CE, Li
    localparam logic [12:0] C_EILM = 13'h01A3; // Ei, Lm
    localparam logic [12:0] C_LDA5 = 13'h02C3; // CE, La
    localparam logic [12:0] C_ADD5 = 13'h02E1; // CE, Lb
    localparam logic [12:0] C_ADD6 = 13'h03C7; // Eu, La
    localparam logic [12:0] C_SUB6 = 13'h03CF; // Eu, La, Su
    localparam logic [12:0] C_OUT4 = 13'h03F2; // Ea, Lo
    localparam logic [12:0] C_JMP4 = 13'h13A3; // Ei, Lp

    typedef struct {
        logic [3:0]  op;
        logic        z;
        logic        n;
        logic [12:0] cw;
        logic [5:0]  t;
        logic [7:0]  cnt;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       run_mode;
    logic       step_req;
    logic [3:0] op;
    logic       fz;
    logic       fn;

    int   n_checks;
    int   n_pass;
    int   exp_cnt;
    vec_t vq[$];

    sap_microsequencer_if #(.NUM_T(6), .OP_W(4), .CNT_W(8)) if_a ();
    sap_microsequencer_if #(.NUM_T(6), .OP_W(4), .CNT_W(8)) if_b ();
    sap_microsequencer_if #(.NUM_T(8), .OP_W(5), .CNT_W(8)) if_c ();
    sap_microsequencer_if #(.NUM_T(8), .OP_W(5), .CNT_W(8)) if_d ();

    assign if_a.run_mode = run_mode; assign if_a.step_req = step_req;
    assign if_a.opcode   = op;       assign if_a.flag_z = fz; assign if_a.flag_n = fn;
    assign if_b.run_mode = run_mode; assign if_b.step_req = step_req;
    assign if_b.opcode   = op;       assign if_b.flag_z = fz; assign if_b.flag_n = fn;
    assign if_c.run_mode = run_mode; assign if_c.step_req = step_req;
    assign if_c.opcode   = {1'b0, op}; assign if_c.flag_z = fz; assign if_c.flag_n = fn;
    assign if_d.run_mode = run_mode; assign if_d.step_req = step_req;
    assign if_d.opcode   = {1'b0, op}; assign if_d.flag_z = fz; assign if_d.flag_n = fn;

    sap_microsequencer #(.NUM_T(6), .OP_W(4), .EARLY_END(1), .CNT_W(8))
        u_a (.clk_i(clk), .rst_i(rst), .bus(if_a));
    sap_microsequencer #(.NUM_T(6), .OP_W(4), .EARLY_END(0), .CNT_W(8))
        u_b (.clk_i(clk), .rst_i(rst), .bus(if_b));
    sap_microsequencer #(.NUM_T(8), .OP_W(5), .EARLY_END(1), .CNT_W(8))
        u_c (.clk_i(clk), .rst_i(rst), .bus(if_c));
    sap_microsequencer #(.NUM_T(8), .OP_W(5), .EARLY_END(0), .CNT_W(8))
        u_d (.clk_i(clk), .rst_i(rst), .bus(if_d));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Inputs change 1 ns after the rising edge; checks sample 1 ns later.
    task automatic step_edge();
        @(posedge clk);
        #1;
    endtask

    // Append one full instruction (fetch + nexec execute states) to the table.
    task automatic push_instr(input logic [3:0] o, input logic z, input logic n,
                              input int nexec, input logic [12:0] c4,
                              input logic [12:0] c5, input logic [12:0] c6);
        logic [12:0] ex [3];
        ex[0] = c4; ex[1] = c5; ex[2] = c6;
        vq.push_back('{o, z, n, C_T1, 6'h01, 8'(exp_cnt)});
        vq.push_back('{o, z, n, C_T2, 6'h02, 8'(exp_cnt)});
        vq.push_back('{o, z, n, C_T3, 6'h04, 8'(exp_cnt)});
        for (int k = 0; k < nexec; k++)
            vq.push_back('{o, z, n, ex[k], 6'(8 << k), 8'(exp_cnt)});
        exp_cnt++;
    endtask

    initial begin
        n_checks = 0; n_pass = 0; exp_cnt = 0;
        run_mode = 1'b0; step_req = 1'b0; op = 4'h0; fz = 1'b0; fn = 1'b0;
        rst = 1'b0;

        // Run-mode instruction stream for the EARLY_END=1 instances
        push_instr(4'b0000, 0, 0, 2, C_EILM, C_LDA5, C_IDLE); // LDA
        push_instr(4'b0001, 0, 0, 3, C_EILM, C_ADD5, C_ADD6); // ADD
        push_instr(4'b0010, 0, 0, 3, C_EILM, C_ADD5, C_SUB6); // SUB
        push_instr(4'b0100, 0, 0, 1, C_IDLE, C_IDLE, C_IDLE); // JZ untaken
        push_instr(4'b0100, 1, 0, 1, C_JMP4, C_IDLE, C_IDLE); // JZ taken
        push_instr(4'b0101, 0, 1, 1, C_JMP4, C_IDLE, C_IDLE); // JN taken
        push_instr(4'b0101, 0, 0, 1, C_IDLE, C_IDLE, C_IDLE); // JN untaken
        push_instr(4'b0011, 0, 0, 1, C_JMP4, C_IDLE, C_IDLE); // JMP
        push_instr(4'b1110, 0, 0, 1, C_OUT4, C_IDLE, C_IDLE); // OUT
        push_instr(4'b0110, 0, 0, 0, C_IDLE, C_IDLE, C_IDLE); // NOP

        // Reset state
        #1 rst = 1'b1;
        #2;
        check("reset t_state", if_a.t_state, 6'h01);
        check("reset cw", if_a.cw, C_IDLE);
        check("reset adv", if_a.adv, 1'b0);
        check("reset halted", if_a.halted, 1'b0);
        check("reset count", if_a.instr_count, 8'h00);
        @(posedge clk); #1;
        rst = 1'b0;
        run_mode = 1'b1;

        // Table-driven instruction stream
        for (int i = 0; i < vq.size(); i++) begin
            op = vq[i].op; fz = vq[i].z; fn = vq[i].n;
            #1;
            check($sformatf("vec%0d cw", i), if_a.cw, vq[i].cw);
            check($sformatf("vec%0d t", i), if_a.t_state, vq[i].t);
            check($sformatf("vec%0d cnt", i), if_a.instr_count, vq[i].cnt);
            check($sformatf("vec%0d adv", i), if_a.adv, 1'b1);
            check($sformatf("vec%0d c_cw", i), if_c.cw, vq[i].cw);
            check($sformatf("vec%0d c_t", i), if_c.t_state, {2'b00, vq[i].t});
            step_edge();
        end
        #1;
        check("stream end t", if_a.t_state, 6'h01);
        check("stream end cnt", if_a.instr_count, 8'd10);

        // Single-step: idle step_req freezes everything
        run_mode = 1'b0; step_req = 1'b0; op = 4'b0001; fz = 1'b0; fn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            check($sformatf("step idle %0d", i), {if_a.adv, if_a.cw, if_a.t_state},
                  {1'b0, C_IDLE, 6'h01});
            step_edge();
        end
        // Three single pulses
        for (int i = 0; i < 3; i++) begin
            step_req = 1'b1;
            #1;
            check($sformatf("pulse %0d adv", i), if_a.adv, 1'b1);
            step_edge();
            step_req = 1'b0;
            step_edge();
        end
        check("after 3 pulses t", if_a.t_state, 6'h08);
        // Held step_req advances every cycle
        step_req = 1'b1;
        step_edge();
        step_edge();
        step_req = 1'b0;
        #1;
        check("held step t", if_a.t_state, 6'h20);
        check("held step cw idle", if_a.cw, C_IDLE);
        // Switch to run mode at T6 of ADD
        run_mode = 1'b1;
        #1;
        check("mode switch cw", if_a.cw, C_ADD6);
        step_edge();
        check("mode switch wrap t", if_a.t_state, 6'h01);
        check("mode switch cnt", if_a.instr_count, 8'd11);

        // CLR during T5 of ADD
        repeat (4) step_edge();
        check("pre-clr t", if_a.t_state, 6'h10);
        #1 rst = 1'b1;
        #1;
        check("clr t", if_a.t_state, 6'h01);
        check("clr cw", if_a.cw, C_IDLE);
        check("clr cnt", if_a.instr_count, 8'h00);
        check("clr halted/adv", {if_a.halted, if_a.adv}, 2'b00);
        rst = 1'b0;

        // HLT
        op = 4'b1111;
        repeat (3) step_edge();
        check("hlt T4 t", if_a.t_state, 6'h08);
        check("hlt T4 cw", if_a.cw, C_IDLE);
        check("hlt T4 adv", if_a.adv, 1'b1);
        step_edge();
        check("halted", if_a.halted, 1'b1);
        check("halt cnt", if_a.instr_count, 8'd1);
        check("halt t frozen", if_a.t_state, 6'h08);
        for (int i = 0; i < 20; i++) begin
            run_mode = i[0];
            step_req = i[1];
            #1;
            check($sformatf("halt hold %0d", i),
                  {if_a.adv, if_a.halted, if_a.cw, if_a.t_state, if_a.instr_count},
                  {1'b0, 1'b1, C_IDLE, 6'h08, 8'd1});
            step_edge();
        end
        run_mode = 1'b0; step_req = 1'b0;
        rst = 1'b1;
        #1;
        check("unhalt t", if_a.t_state, 6'h01);
        check("unhalt halted", if_a.halted, 1'b0);
        rst = 1'b0;

        // instr_count wraps 255 -> 0 (NOP = 3 cycles)
        op = 4'b0110; run_mode = 1'b1;
        repeat (255 * 3) step_edge();
        check("cnt 255", if_a.instr_count, 8'hFF);
        repeat (3) step_edge();
        check("cnt wrap", if_a.instr_count, 8'h00);
        check("cnt wrap t", if_a.t_state, 6'h01);

        // LDA under all four parameter sets
        rst = 1'b1;
        #1;
        op = 4'b0000;
        rst = 1'b0;
        repeat (5) step_edge();
        check("ee1 n6 t", if_a.t_state, 6'h01);
        check("ee1 n6 cnt", if_a.instr_count, 8'd1);
        check("ee1 n8 t", if_c.t_state, 8'h01);
        check("ee1 n8 cnt", if_c.instr_count, 8'd1);
        check("ee0 n6 T6", if_b.t_state, 6'h20);
        check("ee0 n6 T6 cw", if_b.cw, C_IDLE);
        check("ee0 n8 T6", if_d.t_state, 8'h20);
        check("ee0 n6 cnt0", if_b.instr_count, 8'd0);
        step_edge();
        check("ee0 n6 wrap t", if_b.t_state, 6'h01);
        check("ee0 n6 wrap cnt", if_b.instr_count, 8'd1);
        check("ee0 n8 T7", if_d.t_state, 8'h40);
        check("ee0 n8 T7 cw", if_d.cw, C_IDLE);
        step_edge();
        check("ee0 n8 T8", if_d.t_state, 8'h80);
        check("ee0 n8 T8 cw", if_d.cw, C_IDLE);
        check("ee0 n8 cnt0", if_d.instr_count, 8'd0);
        step_edge();
        check("ee0 n8 wrap t", if_d.t_state, 8'h01);
        check("ee0 n8 wrap cnt", if_d.instr_count, 8'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
